// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_controller
// Purpose  : Control FSM for the multicycle RV32 datapath, with cycle and
//            retired-instruction counters for bring-up.
// Options  : ILLEGAL_TRAP_EN - unknown opcodes halt the FSM and raise illegal.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_controller #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode,
    input  logic [2:0]       func3,
    input  logic [6:0]       func7,
    input  logic             zer,
    input  logic             neg,
    output logic             pcen,
    output logic             adrsrc,
    output logic             memwrite,
    output logic             irwrite,
    output logic             regwrite,
    output logic [1:0]       alusrca,
    output logic [1:0]       alusrcb,
    output logic [2:0]       aluop,
    output logic [1:0]       resultsrc,
    output logic [2:0]       immsrc,
    output logic             illegal,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
);

    localparam logic [3:0] c_st_fetch     = 4'd0;
    localparam logic [3:0] c_st_decode    = 4'd1;
    localparam logic [3:0] c_st_memadr    = 4'd2;
    localparam logic [3:0] c_st_memread   = 4'd3;
    localparam logic [3:0] c_st_memwb     = 4'd4;
    localparam logic [3:0] c_st_memwrite  = 4'd5;
    localparam logic [3:0] c_st_execr     = 4'd6;
    localparam logic [3:0] c_st_execi     = 4'd7;
    localparam logic [3:0] c_st_aluwb     = 4'd8;
    localparam logic [3:0] c_st_branch    = 4'd9;
    localparam logic [3:0] c_st_jal       = 4'd10;
    localparam logic [3:0] c_st_jalr_addr = 4'd11;
    localparam logic [3:0] c_st_jalr_jump = 4'd12;
    localparam logic [3:0] c_st_linkwb    = 4'd13;
    localparam logic [3:0] c_st_lui       = 4'd14;
    localparam logic [3:0] c_st_halt      = 4'd15;

    localparam logic [6:0] c_op_r      = 7'b0110011;
    localparam logic [6:0] c_op_i      = 7'b0010011;
    localparam logic [6:0] c_op_load   = 7'b0000011;
    localparam logic [6:0] c_op_store  = 7'b0100011;
    localparam logic [6:0] c_op_branch = 7'b1100011;
    localparam logic [6:0] c_op_jal    = 7'b1101111;
    localparam logic [6:0] c_op_jalr   = 7'b1100111;
    localparam logic [6:0] c_op_lui    = 7'b0110111;

    localparam logic [2:0] c_alu_add  = 3'b000;
    localparam logic [2:0] c_alu_sub  = 3'b001;
    localparam logic [2:0] c_alu_and  = 3'b010;
    localparam logic [2:0] c_alu_or   = 3'b011;
    localparam logic [2:0] c_alu_slt  = 3'b100;
    localparam logic [2:0] c_alu_xor  = 3'b101;
    localparam logic [2:0] c_alu_sltu = 3'b110;

    localparam logic [2:0] c_imm_i = 3'b000;
    localparam logic [2:0] c_imm_s = 3'b001;
    localparam logic [2:0] c_imm_b = 3'b010;
    localparam logic [2:0] c_imm_j = 3'b011;
    localparam logic [2:0] c_imm_u = 3'b100;

    localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [3:0]       r_state;
    logic [3:0]       w_next;
    logic [CNT_W-1:0] r_cycle_cnt;
    logic [CNT_W-1:0] r_instret_cnt;
    logic             w_retire;
    logic             w_pcen;
    logic             w_memwrite;
    logic             w_irwrite;
    logic             w_regwrite;
    logic             w_unused;

    // neg and the remaining func7 bits are reserved for later ISA extensions
    assign w_unused = &{1'b0, neg, func7[6], func7[4:0]};

    function automatic logic [2:0] alu_dec(input logic [2:0] f3, input logic sub);
        logic [2:0] op;
        op = c_alu_add;
        case (f3)
            3'b000:  op = sub ? c_alu_sub : c_alu_add;
            3'b111:  op = c_alu_and;
            3'b110:  op = c_alu_or;
            3'b100:  op = c_alu_xor;
            3'b010:  op = c_alu_slt;
            3'b011:  op = c_alu_sltu;
            default: op = c_alu_add;
        endcase
        return op;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_st_fetch;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = c_st_fetch;
        case (r_state)
            c_st_fetch:  w_next = c_st_decode;
            c_st_decode: begin
                case (opcode)
                    c_op_r:      w_next = c_st_execr;
                    c_op_i:      w_next = c_st_execi;
                    c_op_load,
                    c_op_store:  w_next = c_st_memadr;
                    c_op_branch: w_next = c_st_branch;
                    c_op_jal:    w_next = c_st_jal;
                    c_op_jalr:   w_next = c_st_jalr_addr;
                    c_op_lui:    w_next = c_st_lui;
`ifdef ILLEGAL_TRAP_EN
                    default:     w_next = c_st_halt;
`else
                    default:     w_next = c_st_fetch;
`endif
                endcase
            end
            c_st_memadr:    w_next = (opcode == c_op_load) ? c_st_memread : c_st_memwrite;
            c_st_memread:   w_next = c_st_memwb;
            c_st_execr,
            c_st_execi:     w_next = c_st_aluwb;
            c_st_jal:       w_next = c_st_linkwb;
            c_st_jalr_addr: w_next = c_st_jalr_jump;
            c_st_jalr_jump: w_next = c_st_linkwb;
            c_st_halt:      w_next = c_st_halt;
            default:        w_next = c_st_fetch;
        endcase
    end

    always_comb begin
        w_pcen     = 1'b0;
        adrsrc     = 1'b0;
        w_memwrite = 1'b0;
        w_irwrite  = 1'b0;
        w_regwrite = 1'b0;
        alusrca    = 2'b00;
        alusrcb    = 2'b00;
        aluop      = c_alu_add;
        resultsrc  = 2'b00;
        immsrc     = c_imm_i;
        case (r_state)
            c_st_fetch: begin
                w_irwrite = 1'b1;
                w_pcen    = 1'b1;
                alusrcb   = 2'b10;
                resultsrc = 2'b01;
            end
            c_st_decode: begin
                alusrca = 2'b01;
                alusrcb = 2'b01;
                immsrc  = (opcode == c_op_jal) ? c_imm_j : c_imm_b;
            end
            c_st_memadr: begin
                alusrca = 2'b10;
                alusrcb = 2'b01;
                immsrc  = (opcode == c_op_load) ? c_imm_i : c_imm_s;
            end
            c_st_memread: adrsrc = 1'b1;
            c_st_memwb: begin
                resultsrc  = 2'b10;
                w_regwrite = 1'b1;
            end
            c_st_memwrite: begin
                adrsrc     = 1'b1;
                w_memwrite = 1'b1;
            end
            c_st_execr: begin
                alusrca = 2'b10;
                aluop   = alu_dec(func3, func7[5]);
            end
            c_st_execi: begin
                alusrca = 2'b10;
                alusrcb = 2'b01;
                aluop   = alu_dec(func3, 1'b0);
            end
            c_st_aluwb,
            c_st_linkwb: w_regwrite = 1'b1;
            c_st_branch: begin
                // slt drives zer low when rs1 < rs2, so blt/bge reuse the zero flag
                alusrca = 2'b10;
                case (func3)
                    3'b000: begin aluop = c_alu_sub; w_pcen = zer;  end
                    3'b001: begin aluop = c_alu_sub; w_pcen = !zer; end
                    3'b100: begin aluop = c_alu_slt; w_pcen = !zer; end
                    3'b101: begin aluop = c_alu_slt; w_pcen = zer;  end
                    default: w_pcen = 1'b0;
                endcase
            end
            c_st_jal,
            c_st_jalr_jump: begin
                w_pcen  = 1'b1;
                alusrca = 2'b01;
                alusrcb = 2'b10;
            end
            c_st_jalr_addr: begin
                alusrca = 2'b10;
                alusrcb = 2'b01;
            end
            c_st_lui: begin
                immsrc     = c_imm_u;
                resultsrc  = 2'b11;
                w_regwrite = 1'b1;
            end
            default: ;
        endcase
    end

    // Enables are gated by reset so that nothing is written while held in reset
    assign pcen     = w_pcen & rst;
    assign memwrite = w_memwrite & rst;
    assign irwrite  = w_irwrite & rst;
    assign regwrite = w_regwrite & rst;

`ifdef ILLEGAL_TRAP_EN
    assign illegal = (r_state == c_st_halt);
`else
    assign illegal = 1'b0;
`endif

    assign w_retire = (w_next == c_st_fetch) && (r_state != c_st_halt);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cycle_cnt   <= '0;
            r_instret_cnt <= '0;
        end else begin
            r_cycle_cnt <= r_cycle_cnt + c_cnt_one;
            if (w_retire) begin
                r_instret_cnt <= r_instret_cnt + c_cnt_one;
            end
        end
    end

    assign cycle_cnt   = r_cycle_cnt;
    assign instret_cnt = r_instret_cnt;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_controller
// Purpose  : Scoreboard bench for multicycle_controller; honours ILLEGAL_TRAP_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_controller;

    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [6:0]       opcode = '0;
    logic [2:0]       func3 = '0;
    logic [6:0]       func7 = '0;
    logic             zer = 1'b0;
    logic             neg = 1'b0;
    logic             pcen, adrsrc, memwrite, irwrite, regwrite, illegal;
    logic [1:0]       alusrca, alusrcb, resultsrc;
    logic [2:0]       aluop, immsrc;
    logic [CNT_W-1:0] cycle_cnt, instret_cnt;

    multicycle_controller #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .func3(func3), .func7(func7),
        .zer(zer), .neg(neg), .pcen(pcen), .adrsrc(adrsrc), .memwrite(memwrite),
        .irwrite(irwrite), .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb),
        .aluop(aluop), .resultsrc(resultsrc), .immsrc(immsrc), .illegal(illegal),
        .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        string            name;
        logic [17:0]      ctl;
        logic [CNT_W-1:0] cyc;
        logic [CNT_W-1:0] ret;
    } exp_t;

    exp_t             scb[$];
    int               checks = 0;
    int               failures = 0;
    logic [CNT_W-1:0] exp_cyc = '0;
    logic [CNT_W-1:0] exp_ret = '0;

    // {pcen,adrsrc,memwrite,irwrite,regwrite,alusrca,alusrcb,aluop,resultsrc,immsrc,illegal}
    function automatic logic [17:0] mk(input logic pc, input logic ad, input logic mw,
                                       input logic ir, input logic rw, input logic [1:0] sa,
                                       input logic [1:0] sbb, input logic [2:0] op,
                                       input logic [1:0] rs, input logic [2:0] im,
                                       input logic il);
        return {pc, ad, mw, ir, rw, sa, sbb, op, rs, im, il};
    endfunction

    logic [17:0] v_rst, v_fetch, v_aluwb, v_memread, v_memwb, v_memwrite, v_jump, v_halt;
    initial begin
        v_rst      = mk(0,0,0,0,0,2'b00,2'b10,3'b000,2'b01,3'b000,0);
        v_fetch    = mk(1,0,0,1,0,2'b00,2'b10,3'b000,2'b01,3'b000,0);
        v_aluwb    = mk(0,0,0,0,1,2'b00,2'b00,3'b000,2'b00,3'b000,0);
        v_memread  = mk(0,1,0,0,0,2'b00,2'b00,3'b000,2'b00,3'b000,0);
        v_memwb    = mk(0,0,0,0,1,2'b00,2'b00,3'b000,2'b10,3'b000,0);
        v_memwrite = mk(0,1,1,0,0,2'b00,2'b00,3'b000,2'b00,3'b000,0);
        v_jump     = mk(1,0,0,0,0,2'b01,2'b10,3'b000,2'b00,3'b000,0);
        v_halt     = mk(0,0,0,0,0,2'b00,2'b00,3'b000,2'b00,3'b000,1);
    end

    function automatic logic [17:0] v_decode(input logic [2:0] im);
        return mk(0,0,0,0,0,2'b01,2'b01,3'b000,2'b00,im,0);
    endfunction

    // Monitor: compares every output against the oldest expectation once per cycle
    always @(negedge clk) begin
        exp_t        e;
        logic [17:0] act;
        if (scb.size() > 0) begin
            e   = scb.pop_front();
            act = {pcen, adrsrc, memwrite, irwrite, regwrite, alusrca, alusrcb,
                   aluop, resultsrc, immsrc, illegal};
            checks++;
            if (act !== e.ctl || cycle_cnt !== e.cyc || instret_cnt !== e.ret) begin
                failures++;
                $display("FAIL %s: got ctl=%b cyc=%0d ret=%0d, expected ctl=%b cyc=%0d ret=%0d",
                         e.name, act, cycle_cnt, instret_cnt, e.ctl, e.cyc, e.ret);
            end
        end
    end

    task automatic step(input string name, input logic [17:0] v, input bit adv, input bit retire);
        exp_t e;
        e.name = name;
        e.ctl  = v;
        e.cyc  = exp_cyc;
        e.ret  = exp_ret;
        scb.push_back(e);
        @(posedge clk);
        #1;
        if (adv)    exp_cyc = exp_cyc + 1;
        if (retire) exp_ret = exp_ret + 1;
    endtask

    task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                         input logic z, input logic [2:0] dec_imm, input string name);
        opcode = op;
        func3  = f3;
        func7  = f7;
        zer    = z;
        step({name, ".fetch"}, v_fetch, 1, 0);
        step({name, ".decode"}, v_decode(dec_imm), 1, 0);
    endtask

    task automatic r_type(input string name, input logic [2:0] f3, input logic [6:0] f7,
                          input logic [2:0] op);
        issue(7'b0110011, f3, f7, 1'b0, 3'b010, name);
        step({name, ".execr"}, mk(0,0,0,0,0,2'b10,2'b00,op,2'b00,3'b000,0), 1, 0);
        step({name, ".aluwb"}, v_aluwb, 1, 1);
    endtask

    task automatic i_type(input string name, input logic [2:0] f3, input logic [6:0] f7,
                          input logic [2:0] op);
        issue(7'b0010011, f3, f7, 1'b0, 3'b010, name);
        step({name, ".execi"}, mk(0,0,0,0,0,2'b10,2'b01,op,2'b00,3'b000,0), 1, 0);
        step({name, ".aluwb"}, v_aluwb, 1, 1);
    endtask

    task automatic branch(input string name, input logic [2:0] f3, input logic z,
                          input logic [2:0] op, input logic pc);
        issue(7'b1100011, f3, 7'd0, z, 3'b010, name);
        step({name, ".branch"}, mk(pc,0,0,0,0,2'b10,2'b00,op,2'b00,3'b000,0), 1, 1);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        step("reset", v_rst, 0, 0);
        rst = 1'b1;

        r_type("add",  3'b000, 7'b0000000, 3'b000);
        r_type("sub",  3'b000, 7'b0100000, 3'b001);
        r_type("and",  3'b111, 7'b0000000, 3'b010);
        r_type("or",   3'b110, 7'b0000000, 3'b011);
        r_type("sltu", 3'b011, 7'b0000000, 3'b110);
        i_type("addi", 3'b000, 7'b0100000, 3'b000);
        i_type("xori", 3'b100, 7'b0000000, 3'b101);
        i_type("slti", 3'b010, 7'b0000000, 3'b100);

        issue(7'b0000011, 3'b010, 7'd0, 1'b0, 3'b010, "lw");
        step("lw.memadr", mk(0,0,0,0,0,2'b10,2'b01,3'b000,2'b00,3'b000,0), 1, 0);
        step("lw.memread", v_memread, 1, 0);
        step("lw.memwb", v_memwb, 1, 1);

        issue(7'b0100011, 3'b010, 7'd0, 1'b0, 3'b010, "sw");
        step("sw.memadr", mk(0,0,0,0,0,2'b10,2'b01,3'b000,2'b00,3'b001,0), 1, 0);
        step("sw.memwrite", v_memwrite, 1, 1);

        branch("beq_z1", 3'b000, 1'b1, 3'b001, 1'b1);
        branch("beq_z0", 3'b000, 1'b0, 3'b001, 1'b0);
        branch("bne_z1", 3'b001, 1'b1, 3'b001, 1'b0);
        branch("blt_z0", 3'b100, 1'b0, 3'b100, 1'b1);
        branch("bge_z0", 3'b101, 1'b0, 3'b100, 1'b0);
        branch("bge_z1", 3'b101, 1'b1, 3'b100, 1'b1);
        branch("b_f3_010", 3'b010, 1'b1, 3'b000, 1'b0);

        issue(7'b1101111, 3'b000, 7'd0, 1'b0, 3'b011, "jal");
        step("jal.jal", v_jump, 1, 0);
        step("jal.linkwb", v_aluwb, 1, 1);

        issue(7'b1100111, 3'b000, 7'd0, 1'b0, 3'b010, "jalr");
        step("jalr.addr", mk(0,0,0,0,0,2'b10,2'b01,3'b000,2'b00,3'b000,0), 1, 0);
        step("jalr.jump", v_jump, 1, 0);
        step("jalr.linkwb", v_aluwb, 1, 1);

        issue(7'b0110111, 3'b000, 7'd0, 1'b0, 3'b010, "lui");
        step("lui.lui", mk(0,0,0,0,1,2'b00,2'b00,3'b000,2'b11,3'b100,0), 1, 1);

        // Reset asserted just after entering MEMWRITE must clear it before the next edge
        issue(7'b0100011, 3'b000, 7'd0, 1'b0, 3'b010, "sw2");
        step("sw2.memadr", mk(0,0,0,0,0,2'b10,2'b01,3'b000,2'b00,3'b001,0), 1, 0);
        rst     = 1'b0;
        exp_cyc = '0;
        exp_ret = '0;
        step("abort", v_rst, 0, 0);
        rst = 1'b1;
        r_type("add_after_rst", 3'b000, 7'b0000000, 3'b000);

`ifdef ILLEGAL_TRAP_EN
        issue(7'b0000000, 3'b000, 7'd0, 1'b0, 3'b010, "illegal");
        for (int i = 0; i < 10; i++) step("halt", v_halt, 1, 0);
`else
        opcode = 7'b0000000;
        func3  = 3'b000;
        step("nop.fetch", v_fetch, 1, 0);
        step("nop.decode", v_decode(3'b010), 1, 1);
        step("nop.refetch", v_fetch, 1, 0);
`endif

        for (int i = 0; i < 8 && scb.size() > 0; i++) @(negedge clk);
        if (scb.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain: %0d expectations left, required 0", scb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Control FSM for the multicycle RV32 datapath.
- Consumes opcode/func3/func7/zer/neg from the datapath.
- Drives all datapath enables and mux selects.
- Keeps cycle and retired-instruction counters for bring-up.
- Supports R/I ALU ops, lw, sw, beq/bne/blt/bge, jal, jalr, lui.

Parameters:
- CNT_W, 32, width of cycle_cnt and instret_cnt.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- opcode  in  7  instruction[6:0].
- func3  in  3  instruction[14:12].
- func7  in  7  instruction[31:25].
- zer  in  1  ALU zero flag.
- neg  in  1  ALU negative flag (unused in v1).
- pcen  out  1  PC write enable.
- adrsrc  out  1  memory address select: 0 = PC, 1 = result.
- memwrite  out  1  memory write enable.
- irwrite  out  1  IR/OLDPC load enable.
- regwrite  out  1  register file write enable.
- alusrca  out  2  ALU A select: 00 = PC, 01 = OLDPC, 10 = A reg, 11 = 0.
- alusrcb  out  2  ALU B select: 00 = B reg, 01 = imm, 10 = 4, 11 = 0.
- aluop  out  3  ALU op: 000 add, 001 sub, 010 and, 011 or, 100 slt, 101 xor, 110 sltu.
- resultsrc  out  2  result select: 00 = ALUOut reg, 01 = ALU result, 10 = MDR, 11 = imm.
- immsrc  out  3  immediate type: 000 I, 001 S, 010 B, 011 J, 100 U.
- illegal  out  1  illegal-opcode flag.
- cycle_cnt  out  CNT_W  cycles since reset.
- instret_cnt  out  CNT_W  retired instructions.

Behaviour:
- State register is asynchronously reset to FETCH. Counters reset to 0; illegal resets to 0.
- While rst=0, pcen/irwrite/memwrite/regwrite are forced to 0.
- Outputs are combinational from state, opcode, func3, func7 and zer.
- Default for every output not listed in a state: 0, aluop add.
- FETCH: adrsrc=0, irwrite=1, alusrca=00, alusrcb=10, resultsrc=01, pcen=1 (PC <= PC+4). Next: DECODE.
- DECODE: alusrca=01, alusrcb=01, immsrc=J if opcode jal else B, add. ALUOut <= OLDPC+imm. Next by opcode:
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 0000011 / 0100011 -> MEMADR
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - 1100111 -> JALR_ADDR
  - 0110111 -> LUI
  - other -> FETCH (NOP)
- MEMADR: alusrca=10, alusrcb=01, add, immsrc=I (lw) or S (sw). Next: MEMREAD (lw) or MEMWRITE (sw).
- MEMREAD: adrsrc=1, resultsrc=00. Next: MEMWB.
- MEMWB: resultsrc=10, regwrite=1. Next: FETCH.
- MEMWRITE: adrsrc=1, resultsrc=00, memwrite=1. Next: FETCH.
- EXECR: alusrca=10, alusrcb=00. Next: ALUWB. aluop by func3:
  - 000: sub if func7[5] else add
  - 111: and
  - 110: or
  - 100: xor
  - 010: slt
  - 011: sltu
- EXECI: alusrca=10, alusrcb=01, immsrc=I. aluop as in EXECR, except func3 000 is always add. Next: ALUWB.
- ALUWB: resultsrc=00, regwrite=1. Next: FETCH.
- BRANCH: alusrca=10, alusrcb=00, resultsrc=00 (target held in ALUOut). Next: FETCH.
  - beq (000): aluop sub, pcen=zer.
  - bne (001): aluop sub, pcen=!zer.
  - blt (100): aluop slt, pcen=!zer.
  - bge (101): aluop slt, pcen=zer.
  - Other func3: pcen=0.
- JAL: resultsrc=00, pcen=1; ALU computes OLDPC+4 (alusrca=01, alusrcb=10). Next: LINKWB.
- JALR_ADDR: alusrca=10, alusrcb=01, immsrc=I, add. Next: JALR_JUMP.
- JALR_JUMP: resultsrc=00, pcen=1, alusrca=01, alusrcb=10. Bit0 of the target is not cleared. Next: LINKWB.
- LINKWB: resultsrc=00, regwrite=1 (rd <= OLDPC+4). Next: FETCH.
- LUI: immsrc=U, resultsrc=11, regwrite=1. Next: FETCH.
- cycle_cnt increments every clock when rst=1; wraps at 2^CNT_W.
- instret_cnt increments on the final cycle of each instruction (any transition into FETCH, except from HALT); wraps.
- Reset mid-instruction aborts immediately. The first edge after release executes FETCH.

Optional Feature:
- Macro: ILLEGAL_TRAP_EN.
- Defined: an unknown opcode in DECODE goes to HALT. In HALT all enables are 0, illegal=1, and the FSM stays until reset. Counters: cycle_cnt runs, instret_cnt frozen.
- Undefined: an unknown opcode is a NOP (DECODE -> FETCH, counted as retired). illegal is tied to 0.

Test Plan:
- add x3,x1,x2 with func7=0000000: FETCH, DECODE, EXECR (aluop 000), ALUWB (regwrite=1, resultsrc=00). instret_cnt 0->1 after 4 cycles.
- sub (func7=0100000) -> aluop 001 in EXECR. lw -> 5 cycles, MEMWB has resultsrc=10. sw -> 4 cycles, memwrite=1 only in MEMWRITE, adrsrc=1.
- beq with zer=1 -> pcen=1 in BRANCH. bne with zer=1 -> pcen=0. blt with zer=0 -> pcen=1 and aluop=100.
- jal -> DECODE immsrc=011; JAL pcen=1; LINKWB regwrite=1; 4 cycles total. jalr -> 5 cycles.
- Opcode 0000000 with ILLEGAL_TRAP_EN -> HALT, illegal=1, no enables for 10 cycles. Without the macro -> back to FETCH after 2 cycles.
- rst=0 during MEMWRITE -> memwrite drops to 0 asynchronously, cycle_cnt=0. After release, FETCH with irwrite=1.
